// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter sharing one sequential multiplier among
// N_REQ requesters. Each requester gets the same start/ready/product
// handshake it would have when wired straight to the multiplier.
// It latches start pulses and operands, issues one multiply at a time, and
// returns the product with a one-cycle ready pulse to the owning requester.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_start_i[k]      one-cycle start pulse from requester k
//   req_a_i / req_b_i   packed operands; slot k = [k*W +: W]
//   req_ready_o[k]      one-cycle done pulse to requester k (one-hot or zero)
//   req_prod_o          product of the last completed op; held until the next completion
//   mult_start_o        start pulse to the multiplier
//   mult_a_o/mult_b_o   operands to the multiplier; held through the op
//   mult_ready_i        multiplier done pulse; mult_prod_i is valid in that cycle
//   mult_prod_i         multiplier product
//   busy_o              operation in flight or any request pending
//   ovf_o[k]            sticky: start seen while requester k was already pending
module mult_arb #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 16,
  parameter int unsigned P_W   = 40
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_start_i,
  input  logic [N_REQ*A_W-1:0] req_a_i,
  input  logic [N_REQ*B_W-1:0] req_b_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [P_W-1:0]       req_prod_o,
  output logic                 mult_start_o,
  output logic [A_W-1:0]       mult_a_o,
  output logic [B_W-1:0]       mult_b_o,
  input  logic                 mult_ready_i,
  input  logic [P_W-1:0]       mult_prod_i,
  output logic                 busy_o,
  output logic [N_REQ-1:0]     ovf_o
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state;
  logic [N_REQ-1:0] pend;
  logic [A_W-1:0]   op_a [N_REQ];
  logic [B_W-1:0]   op_b [N_REQ];
  logic [GW-1:0]    grant;
  logic [GW-1:0]    last;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    cand;
  logic             pick_valid;
  logic [N_REQ-1:0] done_clr;

  // Round-robin search: first pending requester after the last grant.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = GW'((32'(last) + i) % N_REQ);
      if (!pick_valid && pend[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Pending bit of the granted requester drops on the completion edge.
  always_comb begin
    done_clr = '0;
    if (state == S_WAIT && mult_ready_i) done_clr[grant] = 1'b1;
  end

  assign busy_o = (state != S_IDLE) || (|pend);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      pend         <= '0;
      grant        <= '0;
      last         <= GW'(N_REQ - 1);
      req_ready_o  <= '0;
      req_prod_o   <= '0;
      mult_start_o <= 1'b0;
      mult_a_o     <= '0;
      mult_b_o     <= '0;
      ovf_o        <= '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
    end else begin
      req_ready_o <= '0;

      // A restart landing on the completion edge is accepted: the old
      // operands are no longer needed, so the new ones may overwrite them.
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (req_start_i[k]) begin
          if (!pend[k] || done_clr[k]) begin
            op_a[k] <= req_a_i[k*A_W +: A_W];
            op_b[k] <= req_b_i[k*B_W +: B_W];
          end else begin
            ovf_o[k] <= 1'b1;
          end
        end
      end
      pend <= (pend & ~done_clr) | req_start_i;

      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant        <= pick;
            mult_start_o <= 1'b1;
            mult_a_o     <= op_a[pick];
            mult_b_o     <= op_b[pick];
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mult_start_o <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_ready_i) begin
            req_prod_o         <= mult_prod_i;
            req_ready_o[grant] <= 1'b1;
            last               <= grant;
            state              <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
